// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Optional add/subtract mode is enabled with SERIAL_SUB_ADD_MODE_EN.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit borrow cell; with SERIAL_SUB_ADD_MODE_EN defined it
// also acts as a full adder when mode=1.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic mode,
`endif
    output logic d,
    output logic bout
);

    always_comb begin
        d = a ^ b ^ bin;
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (mode)
            bout = (a & b) | (a & bin) | (b & bin);
        else
            bout = (~a & b) | (~(a ^ b) & bin);
`else
        bout = (~a & b) | (~(a ^ b) & bin);
`endif
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_ADD_MODE_EN to add the mode port (1 = add, 0 = subtract).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_bff;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             r_mode;
`endif

    full_subtractor u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_bff),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .mode (r_mode),
`endif
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // The minuend register doubles as the result register: each difference
    // bit enters at the MSB as the consumed operand bit leaves the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_bff    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            r_mode   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_bff  <= 1'b0;
                        r_cnt  <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        r_mode <= mode;
`endif
                    end
                end
                SHIFT: begin
                    r_a_sr <= {w_d, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bff  <= w_bout;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff   <= {w_d, r_a_sr[WIDTH-1:1]};
                        r_borrow <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
